// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and constants for the mux scan sequencer slice.
// The sequencer, its bus interface and the wrapper all import this package.
package mux_scan_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] LAST_IDX = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // First select index of a frame: LSB-first starts at 0, MSB-first at 7.
    function automatic logic [SEL_W-1:0] start_idx(input int msb_first);
        return (msb_first != 0) ? LAST_IDX : '0;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Bus between the sequencer (slave) and its surroundings (master): word input,
// mux select/enable side, serial output and FSM debug state.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready;
// in_valid is ignored whenever in_ready is low, and in_data matters only on
// that transfer edge. ser_valid is a one-cycle pulse with no backpressure.
interface mux_scan_sequencer_if;
    import mux_scan_sequencer_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [DATA_W-1:0] A;
    logic [SEL_W-1:0]  s;
    logic              En;
    logic              y;
    logic              ser_bit;
    logic              ser_valid;
    logic              ser_last;
    logic              busy;
    state_t            state_dbg;

    modport master (
        output in_data, in_valid, abort, y,
        input  in_ready, A, s, En, ser_bit, ser_valid, ser_last, busy, state_dbg
    );

    modport slave (
        input  in_data, in_valid, abort, y,
        output in_ready, A, s, En, ser_bit, ser_valid, ser_last, busy, state_dbg
    );

endinterface

// File: rtl/mux_scan_sequencer_mux8to1.sv
// Plain 8:1 bit multiplexer with an enable; output is 0 while disabled.
module mux8to1 (
    input  logic [7:0] A,
    input  logic [2:0] s,
    input  logic       En,
    output logic       y
);

    assign y = En & A[s];

endmodule

// File: rtl/mux_scan_top.sv
// Wrapper closing the loop between the sequencer and the 8:1 mux it drives;
// only the word input and serial output are exposed.
module mux_scan_top
    import mux_scan_sequencer_pkg::*;
#(
    parameter int MSB_FIRST   = 0,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              abort,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy,
    output state_t            state_dbg
);

    mux_scan_sequencer_if bus ();

    assign bus.in_data  = in_data;
    assign bus.in_valid = in_valid;
    assign bus.abort    = abort;
    assign in_ready     = bus.in_ready;
    assign ser_bit      = bus.ser_bit;
    assign ser_valid    = bus.ser_valid;
    assign ser_last     = bus.ser_last;
    assign busy         = bus.busy;
    assign state_dbg    = bus.state_dbg;

    mux8to1 u_mux (
        .A  (bus.A),
        .s  (bus.s),
        .En (bus.En),
        .y  (bus.y)
    );

    mux_scan_sequencer #(
        .MSB_FIRST   (MSB_FIRST),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

endmodule

// File: rtl/mux_scan_sequencer.sv
// Sequencer that walks an 8:1 mux over a captured word and emits one serial
// bit per select index, with a frame-last marker on the eighth bit.
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int MSB_FIRST   = 0,
    parameter int HOLD_CYCLES = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    mux_scan_sequencer_if.slave bus
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic              en_q, en_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [2:0]        bit_q, bit_d;
    logic              ser_bit_q, ser_bit_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_last_q, ser_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            s_q         <= '0;
            en_q        <= 1'b0;
            hold_q      <= '0;
            bit_q       <= '0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            s_q         <= s_d;
            en_q        <= en_d;
            hold_q      <= hold_d;
            bit_q       <= bit_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        s_d         = s_q;
        en_d        = en_q;
        hold_d      = hold_q;
        bit_d       = bit_q;
        ser_bit_d   = ser_bit_q;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // abort is deliberately not looked at here: a word offered
                // together with abort is still accepted.
                if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    s_d     = start_idx(MSB_FIRST);
                    en_d    = 1'b1;
                    hold_d  = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    en_d    = 1'b0;
                    s_d     = '0;
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    // Last cycle of the hold window: y has settled on A[s].
                    hold_d      = '0;
                    ser_bit_d   = bus.y;
                    ser_valid_d = 1'b1;
                    if (bit_q == LAST_IDX) begin
                        ser_last_d = 1'b1;
                        en_d       = 1'b0;
                        s_d        = '0;
                        state_d    = IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        s_d   = (MSB_FIRST != 0) ? s_q - 3'd1 : s_q + 3'd1;
                    end
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.A         = a_q;
    assign bus.s         = s_q;
    assign bus.En        = en_q;
    assign bus.ser_bit   = ser_bit_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: instance 0 is LSB-first with 1-cycle hold,
// instance 1 is MSB-first with 3-cycle hold; the mux is modelled behaviourally.
module tb_mux_scan_sequencer;
  import mux_scan_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- per-instance stimulus and observation ----------------
  logic [7:0] in_data_d [2];
  logic       in_valid_d [2];
  logic       abort_d [2];
  logic [7:0] a_o [2];
  logic [2:0] s_o [2];
  logic       en_o [2];
  logic       ser_bit_o [2];
  logic       ser_valid_o [2];
  logic       ser_last_o [2];
  logic       busy_o [2];
  logic       in_ready_o [2];
  state_t     st_o [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    mux_scan_sequencer_if bus ();

    assign bus.in_data  = in_data_d[g];
    assign bus.in_valid = in_valid_d[g];
    assign bus.abort    = abort_d[g];
    assign bus.y        = bus.En & bus.A[bus.s];

    assign a_o[g]         = bus.A;
    assign s_o[g]         = bus.s;
    assign en_o[g]        = bus.En;
    assign ser_bit_o[g]   = bus.ser_bit;
    assign ser_valid_o[g] = bus.ser_valid;
    assign ser_last_o[g]  = bus.ser_last;
    assign busy_o[g]      = bus.busy;
    assign in_ready_o[g]  = bus.in_ready;
    assign st_o[g]        = bus.state_dbg;

    mux_scan_sequencer #(
      .MSB_FIRST   (g),
      .HOLD_CYCLES ((g == 0) ? 1 : 3)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int hold_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic int idx_of(input int g, input int k);
    return (g == 1) ? 7 - k : k;
  endfunction

  // Serial stream in emission order, first bit in bit 7.
  function automatic logic [7:0] model_stream(input int g, input logic [7:0] w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[6:0], w[idx_of(g, k)]};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_word(input int g, input logic [7:0] w);
    bit ready_seen;
    ready_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_o[g]) begin
        ready_seen = 1;
        break;
      end
    end
    if (!ready_seen) chk("send_ready_timeout", 0, 1);
    in_valid_d[g] = 1'b1;
    in_data_d[g]  = w;
    @(posedge clk);
    #1;
    in_valid_d[g] = 1'b0;
    in_data_d[g]  = $urandom;
  endtask

  // Watches one frame from the first negedge after the accept edge (c = 0)
  // until ser_last or the cycle budget runs out.
  task automatic collect(input int g, input logic [7:0] w, input bit garbage,
                         input int swap_at, input logic [7:0] swap_data,
                         output logic [7:0] stream, output int n,
                         output int t_err, output bit last_ok);
    int hh;
    bit exp_v;
    hh = hold_of(g);
    stream = '0;
    n = 0;
    t_err = 0;
    last_ok = 0;
    for (int c = 0; c <= 8 * hh + 2; c++) begin
      @(negedge clk);
      if (c < 8 * hh) begin
        if (s_o[g] != 3'(idx_of(g, c / hh)) || !en_o[g] || !busy_o[g] ||
            in_ready_o[g] || a_o[g] != w || st_o[g] != SHIFT)
          t_err++;
      end
      exp_v = (c > 0) && (c % hh == 0) && (c <= 8 * hh);
      if (ser_valid_o[g] != exp_v) t_err++;
      if (ser_valid_o[g]) begin
        stream = {stream[6:0], ser_bit_o[g]};
        n++;
      end
      if (ser_last_o[g]) begin
        last_ok = (n == 8) && in_ready_o[g] && !en_o[g] && (s_o[g] == 3'd0) &&
                  !busy_o[g] && (c == 8 * hh);
        break;
      end
      if (c == swap_at) in_data_d[g] = swap_data;
      if (garbage) begin
        if (busy_o[g]) begin
          in_valid_d[g] = 1'($urandom_range(0, 1));
          in_data_d[g]  = $urandom;
        end else begin
          in_valid_d[g] = 1'b0;
        end
      end
    end
    if (garbage) in_valid_d[g] = 1'b0;
  endtask

  task automatic judge(input string name, input logic [7:0] exp,
                       input logic [7:0] stream, input int n, input int t_err, input bit last_ok);
    chk({name, "_stream"}, stream, exp);
    chk({name, "_count"}, n, 8);
    chk({name, "_timing_errs"}, t_err, 0);
    chk({name, "_last"}, last_ok, 1);
  endtask

  task automatic run_frame(input int g, input logic [7:0] w, input logic [7:0] exp,
                           input string name, input bit garbage);
    logic [7:0] stream;
    int n, t_err;
    bit last_ok;
    send_word(g, w);
    collect(g, w, garbage, -1, 8'h00, stream, n, t_err, last_ok);
    judge(name, exp, stream, n, t_err, last_ok);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         g;
    logic [7:0] word;
    logic [7:0] exp;   // serial bits, first emitted in bit 7
  } vec_t;

  vec_t vecs [6];

  // ---------------- main test ----------------
  initial begin
    logic [7:0] stream;
    int n, t_err, cnt;
    bit last_ok;
    logic [7:0] w;
    int g;

    vecs[0] = '{g: 0, word: 8'b01011010, exp: 8'b01011010};
    vecs[1] = '{g: 1, word: 8'b01011010, exp: 8'b01011010};
    vecs[2] = '{g: 0, word: 8'hA5,       exp: 8'b10100101};
    vecs[3] = '{g: 0, word: 8'h3C,       exp: 8'b00111100};
    vecs[4] = '{g: 1, word: 8'h01,       exp: 8'b00000001};
    vecs[5] = '{g: 1, word: 8'h80,       exp: 8'b10000000};

    checks = 0;
    errors = 0;

    // Reset held with a word offered: nothing may be captured.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_d[i] = 1'b1;
      in_data_d[i]  = 8'hEE;
      abort_d[i]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_A", a_o[0], 8'h00);
    chk("rst_s", s_o[0], 3'd0);
    chk("rst_En", en_o[0], 1'b0);
    chk("rst_ser_valid", ser_valid_o[0], 1'b0);
    chk("rst_busy", busy_o[0], 1'b0);
    chk("rst_state", st_o[1], IDLE);
    rst_n = 1'b1;
    in_valid_d[0] = 1'b0;
    in_valid_d[1] = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_o[0], 1'b1);
    chk("post_rst_no_capture", a_o[0], 8'h00);

    // Table-driven frames.
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].g, vecs[i].word, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);

    // Back-to-back: A5 accepted, in_valid held with an intermediate word,
    // then 3C, which must be accepted exactly in the ser_last cycle.
    send_word(0, 8'hA5);
    in_valid_d[0] = 1'b1;
    in_data_d[0]  = 8'h77;
    collect(0, 8'hA5, 1'b0, 4, 8'h3C, stream, n, t_err, last_ok);
    judge("b2b_first", 8'b10100101, stream, n, t_err, last_ok);
    @(posedge clk);
    #1;
    in_valid_d[0] = 1'b0;
    collect(0, 8'h3C, 1'b0, -1, 8'h00, stream, n, t_err, last_ok);
    judge("b2b_second", 8'b00111100, stream, n, t_err, last_ok);

    // Abort after the third serial bit.
    send_word(0, 8'h5A);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ser_valid_o[0]) cnt++;
      if (cnt == 3) break;
    end
    chk("abort_pre_count", cnt, 3);
    abort_d[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_d[0] = 1'b0;
    @(negedge clk);
    chk("abort_En", en_o[0], 1'b0);
    chk("abort_s", s_o[0], 3'd0);
    chk("abort_ser_valid", ser_valid_o[0], 1'b0);
    chk("abort_ser_last", ser_last_o[0], 1'b0);
    chk("abort_in_ready", in_ready_o[0], 1'b1);
    chk("abort_A_kept", a_o[0], 8'h5A);
    cnt = 0;
    abort_d[0] = 1'b1;   // abort while idle must be harmless
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ser_valid_o[0] || ser_last_o[0] || busy_o[0] || en_o[0]) cnt++;
    end
    chk("abort_idle_quiet", cnt, 0);
    // abort together with a word in IDLE: the word wins.
    in_valid_d[0] = 1'b1;
    in_data_d[0]  = 8'hFF;
    @(posedge clk);
    #1;
    in_valid_d[0] = 1'b0;
    abort_d[0]    = 1'b0;
    collect(0, 8'hFF, 1'b0, -1, 8'h00, stream, n, t_err, last_ok);
    judge("after_abort_ff", 8'hFF, stream, n, t_err, last_ok);

    // Asynchronous reset between edges in the middle of a frame.
    send_word(0, 8'hC3);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_A", a_o[0], 8'h00);
    chk("midrst_s", s_o[0], 3'd0);
    chk("midrst_En", en_o[0], 1'b0);
    chk("midrst_ser_valid", ser_valid_o[0], 1'b0);
    chk("midrst_ser_last", ser_last_o[0], 1'b0);
    chk("midrst_busy", busy_o[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 8'h01, 8'b10000000, "after_rst_01", 1'b0);

    // Random frames on both instances with junk offered while busy.
    for (int i = 0; i < 30; i++) begin
      g = $urandom_range(0, 1);
      w = 8'($urandom);
      exp_q.push_back(model_stream(g, w));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame(g, w, exp_q.pop_front(), $sformatf("rand%0d", i), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Sequencer stage that drives the select/enable side of an 8:1 bit mux and consumes its output, turning an accepted 8-bit word into a timed serial bit stream.
- Accepts a word on a valid/ready handshake and presents it on A.
- Steps s through all eight indices with En high, registers y once per index, and emits one serial bit per index with a frame-last marker.
- Sits between a word producer (upstream) and a serial consumer (downstream), wrapped around mux8to1.

Parameters:
- MSB_FIRST, 0, 0: s steps 0→7 (LSB first); 1: s steps 7→0.
- HOLD_CYCLES, 1, clock cycles each select value is held (≥1); y is sampled on the last cycle of each hold window.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer can accept a word.
- abort  in  1  synchronous frame abort.
- A  out  8  registered data word to mux.
- s  out  3  select to mux.
- En  out  1  mux enable.
- y  in  1  mux output (combinational from A/s/En).
- ser_bit  out  1  serial data bit.
- ser_valid  out  1  one-cycle pulse per bit.
- ser_last  out  1  high with the 8th bit of a frame.
- busy  out  1  frame in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - A=0, s=0, En=0, ser_bit=0, ser_valid=0, ser_last=0, busy=0.
  - in_ready=1 once rst_n is released.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - in_ready=1, En=0, busy=0, s=0.
  - On an edge with in_valid&in_ready: A<=in_data; s<=start index (0, or 7 if MSB_FIRST); En<=1; hold counter<=0; bit counter<=0; go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1, En=1; A and s are stable for the whole hold window.
  - Hold counter counts 0..HOLD_CYCLES-1. On the edge where it equals HOLD_CYCLES-1: ser_bit<=y, ser_valid<=1, and s advances (+1 or −1). Otherwise ser_valid<=0.
  - Bit counter counts 0..7. When it reaches 7 at end of a window: ser_last<=1, En<=0, s<=0, go to IDLE.
- Latency with HOLD_CYCLES=1 and the accept edge as edge 0:
  - s/En valid from edge 0 onward.
  - ser_valid high after edges 1..8; ser_last with the bit registered at edge 8.
  - in_ready is high in the same cycle as ser_last.
- Frame period is 8*HOLD_CYCLES+1 cycles minimum; back-to-back frames are legal.
- Handshake rules:
  - in_valid while busy is ignored and produces no side effect.
  - in_data is only captured on the accept edge.
- abort:
  - Sampled each edge in SHIFT; on assertion go to IDLE: En<=0, s<=0, ser_valid<=0, ser_last<=0. A keeps its value.
  - abort in IDLE has no effect.
  - abort and in_valid together in IDLE: the word is accepted (abort ignored).
- s wrap: never wraps within a frame; the index sequence is exactly 8 values.
- Widths:
  - Hold counter width is $clog2(HOLD_CYCLES+1).
  - Bit counter is 3 bits.
  - No arithmetic overflow is possible.
- Reset mid-frame: all outputs return to reset values immediately, no partial ser_last, and the next frame starts clean.

Decomposition:
- Shared package:
  - State enum: IDLE, SHIFT.
  - Constants DATA_W=8, SEL_W=3, LAST_IDX=7.
- One sub-module is natural: mux8to1.
  - Instantiate it in a wrapper (mux_scan_top) connecting A/s/En/y.
  - The sequencer itself contains no mux logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 → A=0, s=0, En=0, ser_valid=0, busy=0; in_ready=1 after release; no capture during reset.
- LSB-first frame: in_data=8'b01011010, HOLD_CYCLES=1, MSB_FIRST=0 → s sequence 0..7 with En=1; ser_bit stream 0,1,0,1,1,0,1,0 on 8 consecutive ser_valid pulses; ser_last on the 8th; in_ready=1 that cycle.
- MSB-first, HOLD_CYCLES=3: in_data=8'b01011010 → s sequence 7..0, each held 3 cycles; ser_bit stream 0,1,0,1,1,0,1,0 (bits 7..0), one ser_valid every 3 cycles; frame 25 cycles.
- Busy/back-to-back:
  - Hold in_valid high with 8'hA5 then 8'h3C → second word accepted only in the ser_last cycle; ser_bit streams are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
  - An intermediate word driven mid-frame is not captured.
- Abort after the 3rd ser_valid → En=0 and s=0 next cycle; no ser_last; in_ready=1; next word 8'hFF yields eight 1s.
- rst_n pulsed low mid-frame (asynchronous, between edges) → outputs go to reset values before the next edge; the following frame of 8'h01 yields 1,0,0,0,0,0,0,0.
